ca_code_mc_gen: RTL and testbench

CA_CODE_MC_GEN -- requirements
Module: ca_code_mc_gen

---
 rtl/ca_code_mc_gen.sv | 159 +++++++++++++++
 tb/tb_ca_code_mc_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_code_mc_gen.sv
// Multi-channel GPS L1 C/A code generator.
// Each channel holds a G1/G2 Gold-code LFSR pair, a code-phase counter and a
// small IDLE/SLEW/RUN FSM. A configuration request restarts one channel at
// chip 0 and slews it forward by cfg_phase chips. After that the channel
// advances one chip on every chip_en strobe.
module ca_code_mc_gen #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [5:0]           cfg_prn,
  input  logic [9:0]           cfg_phase,
  output logic                 cfg_err,
  input  logic [NUM_CH-1:0]    chip_en,
  output logic [NUM_CH-1:0]    ca_code,
  output logic [NUM_CH*10-1:0] code_phase,
  output logic [NUM_CH-1:0]    epoch,
  output logic [NUM_CH-1:0]    running
);

  typedef enum logic [1:0] {ST_IDLE, ST_SLEW, ST_RUN} ch_state_t;

  localparam logic [9:0] LAST_CHIP = 10'd1022;

  // G2 phase-selector taps for each PRN, returned as a one-hot pair over
  // stages 1..10. Bit i of the mask corresponds to stage i+1.
  function automatic logic [9:0] prn_mask(input logic [5:0] prn);
    logic [3:0] a;
    logic [3:0] b;
    case (prn)
      6'd1:  begin a = 4'd2; b = 4'd6;  end
      6'd2:  begin a = 4'd3; b = 4'd7;  end
      6'd3:  begin a = 4'd4; b = 4'd8;  end
      6'd4:  begin a = 4'd5; b = 4'd9;  end
      6'd5:  begin a = 4'd1; b = 4'd9;  end
      6'd6:  begin a = 4'd2; b = 4'd10; end
      6'd7:  begin a = 4'd1; b = 4'd8;  end
      6'd8:  begin a = 4'd2; b = 4'd9;  end
      6'd9:  begin a = 4'd3; b = 4'd10; end
      6'd10: begin a = 4'd2; b = 4'd3;  end
      6'd11: begin a = 4'd3; b = 4'd4;  end
      6'd12: begin a = 4'd5; b = 4'd6;  end
      6'd13: begin a = 4'd6; b = 4'd7;  end
      6'd14: begin a = 4'd7; b = 4'd8;  end
      6'd15: begin a = 4'd8; b = 4'd9;  end
      6'd16: begin a = 4'd9; b = 4'd10; end
      6'd17: begin a = 4'd1; b = 4'd4;  end
      6'd18: begin a = 4'd2; b = 4'd5;  end
      6'd19: begin a = 4'd3; b = 4'd6;  end
      6'd20: begin a = 4'd4; b = 4'd7;  end
      6'd21: begin a = 4'd5; b = 4'd8;  end
      6'd22: begin a = 4'd6; b = 4'd9;  end
      6'd23: begin a = 4'd1; b = 4'd3;  end
      6'd24: begin a = 4'd4; b = 4'd6;  end
      6'd25: begin a = 4'd5; b = 4'd7;  end
      6'd26: begin a = 4'd6; b = 4'd8;  end
      6'd27: begin a = 4'd7; b = 4'd9;  end
      6'd28: begin a = 4'd8; b = 4'd10; end
      6'd29: begin a = 4'd1; b = 4'd6;  end
      6'd30: begin a = 4'd2; b = 4'd7;  end
      6'd31: begin a = 4'd3; b = 4'd8;  end
      6'd32: begin a = 4'd4; b = 4'd9;  end
      default: begin a = 4'd1; b = 4'd1; end
    endcase
    return (10'd1 << (a - 4'd1)) | (10'd1 << (b - 4'd1));
  endfunction

  logic              cfg_fire;
  logic              prn_ok;
  logic              phase_ok;
  logic              ch_ok;
  logic [NUM_CH-1:0] slewing;

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign prn_ok    = (cfg_prn >= 6'd1) && (cfg_prn <= 6'd32);
  assign phase_ok  = (cfg_phase <= LAST_CHIP);
  assign ch_ok     = (int'(cfg_ch) < NUM_CH);
  // Only one channel can slew at a time, because no request is accepted
  // while any channel is slewing.
  assign cfg_ready = ~|slewing;

  // Error pulse, one cycle after an invalid request is accepted.
  // NOTE: sequential state always uses non-blocking assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_fire && !(prn_ok && phase_ok && ch_ok);
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    ch_state_t  state;
    logic [9:0] g1;
    logic [9:0] g2;
    logic [9:0] tap_mask;
    logic [9:0] count;
    logic [9:0] slew_cnt;
    logic       epoch_r;
    logic       sel;
    logic       advance;

    // An out-of-range cfg_ch never matches, so it leaves every channel alone.
    assign sel     = cfg_fire && (int'(cfg_ch) == n);
    assign advance = (state == ST_SLEW) || ((state == ST_RUN) && chip_en[n]);

    // Channel FSM, LFSR pair, code-phase counter and epoch flag.
    // NOTE: the LFSRs, tap mask and slew counter are not reset. Every path
    // out of IDLE loads them first, and ca_code is masked while IDLE.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= ST_IDLE;
        count   <= '0;
        epoch_r <= 1'b0;
      end else begin
        epoch_r <= 1'b0;
        if (sel) begin
          if (prn_ok && phase_ok) begin
            g1       <= '1;
            g2       <= '1;
            tap_mask <= prn_mask(cfg_prn);
            count    <= '0;
            slew_cnt <= cfg_phase;
            state    <= (cfg_phase != 10'd0) ? ST_SLEW : ST_RUN;
          end else begin
            state <= ST_IDLE;
            count <= '0;
          end
        end else begin
          if (advance) begin
            if (count == LAST_CHIP) begin
              count   <= '0;
              g1      <= '1;
              g2      <= '1;
              epoch_r <= (state == ST_RUN);
            end else begin
              count <= count + 10'd1;
              g1    <= {g1[8:0], g1[2] ^ g1[9]};
              g2    <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
            end
          end
          if (state == ST_SLEW) begin
            slew_cnt <= slew_cnt - 10'd1;
            if (slew_cnt == 10'd1) state <= ST_RUN;
          end
        end
      end
    end

    assign slewing[n]           = (state == ST_SLEW);
    assign running[n]           = (state == ST_RUN);
    assign epoch[n]             = epoch_r;
    assign code_phase[10*n +: 10] = count;
    assign ca_code[n]           = (state != ST_IDLE) && (g1[9] ^ (^(g2 & tap_mask)));
  end

endmodule

// File: tb/tb_ca_code_mc_gen.sv
// Directed, self-checking bench for ca_code_mc_gen. It uses three channels,
// so cfg_ch = 3 is an out-of-range channel index. Expected chips come from
// hand-computed constants and from an independent G1/G2 reference model.
`timescale 1ns/1ps
module tb_ca_code_mc_gen;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [5:0]           cfg_prn;
  logic [9:0]           cfg_phase;
  logic                 cfg_err;
  logic [NUM_CH-1:0]    chip_en;
  logic [NUM_CH-1:0]    ca_code;
  logic [NUM_CH*10-1:0] code_phase;
  logic [NUM_CH-1:0]    epoch;
  logic [NUM_CH-1:0]    running;

  int checks = 0;
  int errors = 0;

  ca_code_mc_gen #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_prn(cfg_prn), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .chip_en(chip_en), .ca_code(ca_code), .code_phase(code_phase),
    .epoch(epoch), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  // Phase-selector taps for PRN 1..32.
  int taps_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int taps_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  // Reference chip idx of PRN prn. Stages are numbered 1..10, as in the ICD.
  function automatic logic ref_chip(input int prn, input int idx);
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int j = 1; j <= 10; j++) begin g1[j] = 1'b1; g2[j] = 1'b1; end
    for (int k = 0; k < idx; k++) begin
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int j = 10; j >= 2; j--) begin g1[j] = g1[j-1]; g2[j] = g2[j-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
    return g1[10] ^ g2[taps_a[prn-1]] ^ g2[taps_b[prn-1]];
  endfunction

  function automatic logic [9:0] cp(input int n);
    return code_phase[10*n +: 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge, using whatever chip_en is current.
  task automatic cfg(input logic [1:0] ch, input logic [5:0] prn, input logic [9:0] ph);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_prn   = prn;
    cfg_phase = ph;
    tick();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [5:0] prn;
    logic [9:0] phase;
    logic       exp_err;
    logic [2:0] exp_run;
    logic [2:0] exp_ca;
  } cfg_vec_t;

  cfg_vec_t vecs [8];

  initial begin
    logic [9:0] word;
    logic [4:0] w5;
    int low_cycles, n_ep, ep_at, ep_cp, ep1, ep2;

    vecs[0] = '{2'd0, 6'd1,  10'd0,    1'b0, 3'b001, 3'b001};
    vecs[1] = '{2'd1, 6'd2,  10'd0,    1'b0, 3'b011, 3'b011};
    vecs[2] = '{2'd2, 6'd0,  10'd0,    1'b1, 3'b011, 3'b011};
    vecs[3] = '{2'd2, 6'd33, 10'd0,    1'b1, 3'b011, 3'b011};
    vecs[4] = '{2'd2, 6'd32, 10'd0,    1'b0, 3'b111, 3'b111};
    vecs[5] = '{2'd2, 6'd32, 10'd1023, 1'b1, 3'b011, 3'b011};
    vecs[6] = '{2'd3, 6'd1,  10'd0,    1'b1, 3'b011, 3'b011};
    vecs[7] = '{2'd2, 6'd63, 10'd1022, 1'b1, 3'b011, 3'b011};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_prn = '0; cfg_phase = '0; chip_en = '0;
    tick(); tick();
    check("rst_ready", cfg_ready, 1);
    check("rst_running", running, 0);
    check("rst_ca", ca_code, 0);
    check("rst_phase", code_phase, 0);
    check("rst_epoch", epoch, 0);
    check("rst_err", cfg_err, 0);
    rst = 1'b0;
    tick();

    // Configuration vectors, applied with chip_en low.
    for (int i = 0; i < 8; i++) begin
      cfg(vecs[i].ch, vecs[i].prn, vecs[i].phase);
      check($sformatf("vec%0d_err", i), cfg_err, vecs[i].exp_err);
      check($sformatf("vec%0d_run", i), running, vecs[i].exp_run);
      check($sformatf("vec%0d_ca", i), ca_code, vecs[i].exp_ca);
      check($sformatf("vec%0d_phase", i), code_phase, 0);
      check($sformatf("vec%0d_ready", i), cfg_ready, 1);
      tick();
      check($sformatf("vec%0d_err_pulse", i), cfg_err, 0);
    end

    // Ch0 PRN1: the first ten chips are octal 1440. Ch1 stays put meanwhile.
    chip_en = 3'b001;
    word = '0;
    for (int k = 0; k < 10; k++) begin
      word[9-k] = ca_code[0];
      if (cp(1) != 10'd0) check("ch1_held", cp(1), 0);
      if (k < 9) tick();
    end
    check("prn1_first10", word, 10'b1100100000);
    check("ch0_phase9", cp(0), 9);

    // Ch1 PRN2 restarts while ch0 keeps advancing: octal 1620.
    chip_en = 3'b011;
    cfg(2'd1, 6'd2, 10'd0);
    check("ch0_phase10", cp(0), 10);
    check("ch1_restart", cp(1), 0);
    for (int k = 0; k < 10; k++) begin
      word[9-k] = ca_code[1];
      check($sformatf("ch0_parallel_%0d", k), ca_code[0], ref_chip(1, 10 + k));
      if (k < 9) tick();
    end
    check("prn2_first10", word, 10'b1110010000);
    chip_en = 3'b000;
    tick();

    // Ch2 PRN1 with phase 5: five slew cycles, then RUN at code_phase 5.
    cfg(2'd2, 6'd1, 10'd5);
    low_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (cfg_ready) break;
      if (epoch != 0) check("slew_no_epoch", epoch, 0);
      low_cycles++;
      tick();
    end
    check("slew_ready_low", low_cycles, 5);
    check("slew_running", running[2], 1);
    check("slew_phase5", cp(2), 5);
    chip_en = 3'b100;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) w5[4-k] = ca_code[2];
      check($sformatf("slew_chip%0d", 5 + k), ca_code[2], ref_chip(1, 5 + k));
      if (k < 9) tick();
    end
    check("slew_chips5_9", w5, 5'b00000);
    chip_en = 3'b000;

    // Restart ch0 while running, colliding with chip_en: request wins, no epoch.
    chip_en = 3'b001;
    cfg(2'd0, 6'd1, 10'd0);
    check("restart_phase", cp(0), 0);
    check("restart_epoch", epoch[0], 0);

    // 1023 strobes give exactly one epoch, at the wrap back to chip 0.
    n_ep = 0; ep_at = -1; ep_cp = -1;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (epoch[0]) begin n_ep++; ep_at = i; ep_cp = cp(0); end
    end
    check("epoch_count", n_ep, 1);
    check("epoch_when", ep_at, 1023);
    check("epoch_phase", ep_cp, 0);
    chip_en = 3'b000;
    tick();
    check("epoch_one_cycle", epoch[0], 0);
    chip_en = 3'b001;
    for (int k = 0; k < 10; k++) begin
      word[9-k] = ca_code[0];
      if (k < 9) tick();
    end
    check("prn1_repeat", word, 10'b1100100000);

    // 50 % chip_en duty cycle: epochs 2046 clocks apart.
    ep1 = -1; ep2 = -1;
    for (int c = 1; c <= 5000; c++) begin
      chip_en = {2'b00, c[0]};
      tick();
      if (epoch[0]) begin
        if (ep1 < 0) ep1 = c;
        else begin ep2 = c; break; end
      end
    end
    check("half_rate_found", (ep1 > 0) && (ep2 > 0), 1);
    check("half_rate_spacing", ep2 - ep1, 2046);

    // Reconfigure at chip 1022 with chip_en high: no wrap epoch, phase 0.
    chip_en = 3'b001;
    for (int k = 0; k < 1100; k++) begin
      if (cp(0) == 10'd1022) break;
      tick();
    end
    check("reach_1022", cp(0), 1022);
    cfg(2'd0, 6'd1, 10'd0);
    check("cfg_at_1022_phase", cp(0), 0);
    check("cfg_at_1022_epoch", epoch[0], 0);
    check("cfg_at_1022_ca", ca_code[0], 1);
    chip_en = 3'b000;
    tick();

    // Reset at slew cycle 3 of a phase-500 load.
    cfg(2'd2, 6'd1, 10'd500);
    check("slew500_ready", cfg_ready, 0);
    tick(); tick();
    check("slew500_cycle3_phase", cp(2), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", cfg_ready, 1);
    check("abort_running", running, 0);
    check("abort_phase", code_phase, 0);
    check("abort_epoch", epoch, 0);
    check("abort_err", cfg_err, 0);
    check("abort_ca", ca_code, 0);
    chip_en = 3'b111;
    cfg(2'd0, 6'd1, 10'd0);
    check("post_rst_phase", code_phase, 0);
    check("post_rst_running", running, 3'b001);
    chip_en = 3'b000;
    tick();
    check("post_rst_err", cfg_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
